csr_trap_controller: RTL

Sequencer that owns the single write port and single read port of the machine-mode CSR file. It arbitrates between pipeline CSR instructions and multi-cycle trap entry / `mret` sequences, and performs the required read-modify-write of `mstatus`. It emits a one-cycle PC redirect to the fetch stage and holds `busy` to stall the pipeline while a sequence runs. It sits between the execute/commit stage and the CSR file.

---
 rtl/csr_pkg.sv | 54 +++++
 rtl/csr_trap_controller_if.sv | 48 ++++
 rtl/csr_trap_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared CSR indices, mstatus bit positions and controller state encoding.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package csr_pkg;

    typedef enum logic [3:0] {
        MSTATUS = 4'd0,
        MIE     = 4'd1,
        MIP     = 4'd4,
        MTVEC   = 4'd8,
        MEPC    = 4'd9,
        MCAUSE  = 4'd10,
        MTVAL   = 4'd11
    } destinationCSR_;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Machine external interrupt, interrupt bit set.
    localparam logic [31:0] INT_CAUSE_DEFAULT = 32'h8000_000B;

    typedef enum logic [2:0] {
        IDLE,
        TRAP_EPC,
        TRAP_CAUSE,
        TRAP_TVAL,
        TRAP_STATUS,
        MRET_STATUS,
        REDIRECT
    } ctrlState_;

    // mstatus after trap entry: stack MIE into MPIE, disable, previous mode M.
    function automatic logic [31:0] trapStatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE] = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    // mstatus after mret: restore MIE from MPIE, MPIE set, stay in M-mode.
    function automatic logic [31:0] mretStatus(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE] = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/csr_trap_controller_if.sv
// Bundle of pipeline-side and CSR-file-side signals around the trap controller.
// Latency: none (wires only).
// Backpressure: busy stalls the pipeline; requests must be held while it is high.
interface csr_trap_controller_if;
    import csr_pkg::*;

    logic           exceptionValid;
    logic [31:0]    exceptionCause;
    logic [31:0]    exceptionPC;
    logic [31:0]    exceptionValue;
    logic           interrupt;
    logic [31:0]    interruptPC;
    logic           mretValid;
    logic           pipeWriteEnable;
    destinationCSR_ pipeWriteCSR;
    logic [31:0]    pipeWriteData;
    destinationCSR_ pipeReadCSR;
    logic [31:0]    pipeReadData;
    logic           busy;
    logic           redirectValid;
    logic [31:0]    redirectPC;
    destinationCSR_ csrReadCSR;
    logic [31:0]    csrReadData;
    destinationCSR_ destinationCSR;
    logic [31:0]    csrWriteData;
    logic           csrDestinationEnable;

    // Pipeline plus CSR file side.
    modport master (
        output exceptionValid, exceptionCause, exceptionPC, exceptionValue,
        output interrupt, interruptPC, mretValid,
        output pipeWriteEnable, pipeWriteCSR, pipeWriteData, pipeReadCSR,
        input  pipeReadData, busy, redirectValid, redirectPC,
        input  csrReadCSR, destinationCSR, csrWriteData, csrDestinationEnable,
        output csrReadData
    );

    // Controller side.
    modport slave (
        input  exceptionValid, exceptionCause, exceptionPC, exceptionValue,
        input  interrupt, interruptPC, mretValid,
        input  pipeWriteEnable, pipeWriteCSR, pipeWriteData, pipeReadCSR,
        output pipeReadData, busy, redirectValid, redirectPC,
        output csrReadCSR, destinationCSR, csrWriteData, csrDestinationEnable,
        input  csrReadData
    );

endinterface

// File: rtl/csr_trap_controller.sv
// Owns the CSR file ports: pipeline CSR ops, trap entry and mret sequences with mstatus RMW.
// Latency: trap = 4 writes then redirect (T+5), mret = 1 write then redirect (T+2); pipeline ops same cycle.
// Backpressure: combinational busy from the accept cycle until back in IDLE; pipeline holds its request.
module csr_trap_controller
    import csr_pkg::*;
#(
    parameter logic [31:0] INT_CAUSE = INT_CAUSE_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    csr_trap_controller_if.slave bus
);

    ctrlState_   state;
    ctrlState_   nextState;
    logic [31:0] causeLatch;
    logic [31:0] epcLatch;
    logic [31:0] tvalLatch;
    logic        isMret;
    logic        mieShadow;
    logic        takeException;
    logic        takeMret;
    logic        takeInterrupt;

    // Next state, event acceptance and all CSR-file / pipeline outputs.
    always_comb begin
        nextState                = state;
        takeException            = 1'b0;
        takeMret                 = 1'b0;
        takeInterrupt            = 1'b0;
        bus.busy                 = 1'b1;
        bus.csrReadCSR           = MSTATUS;
        bus.pipeReadData         = '0;
        bus.destinationCSR       = MSTATUS;
        bus.csrWriteData         = '0;
        bus.csrDestinationEnable = 1'b0;
        bus.redirectValid        = 1'b0;
        bus.redirectPC           = '0;

        case (state)
            IDLE: begin
                bus.busy         = 1'b0;
                bus.csrReadCSR   = bus.pipeReadCSR;
                bus.pipeReadData = bus.csrReadData;
                if (bus.exceptionValid) begin
                    takeException = 1'b1;
                    bus.busy      = 1'b1;
                    nextState     = TRAP_EPC;
                end else if (bus.mretValid) begin
                    takeMret  = 1'b1;
                    bus.busy  = 1'b1;
                    nextState = MRET_STATUS;
                end else if (bus.interrupt && mieShadow) begin
                    takeInterrupt = 1'b1;
                    bus.busy      = 1'b1;
                    nextState     = TRAP_EPC;
                end else if (bus.pipeWriteEnable) begin
                    bus.destinationCSR       = bus.pipeWriteCSR;
                    bus.csrWriteData         = bus.pipeWriteData;
                    bus.csrDestinationEnable = 1'b1;
                end
            end
            TRAP_EPC: begin
                bus.destinationCSR       = MEPC;
                bus.csrWriteData         = epcLatch & ~32'd3;
                bus.csrDestinationEnable = 1'b1;
                nextState                = TRAP_CAUSE;
            end
            TRAP_CAUSE: begin
                bus.destinationCSR       = MCAUSE;
                bus.csrWriteData         = causeLatch;
                bus.csrDestinationEnable = 1'b1;
                nextState                = TRAP_TVAL;
            end
            TRAP_TVAL: begin
                bus.destinationCSR       = MTVAL;
                bus.csrWriteData         = tvalLatch;
                bus.csrDestinationEnable = 1'b1;
                nextState                = TRAP_STATUS;
            end
            TRAP_STATUS: begin
                bus.csrReadCSR           = MSTATUS;
                bus.destinationCSR       = MSTATUS;
                bus.csrWriteData         = trapStatus(bus.csrReadData);
                bus.csrDestinationEnable = 1'b1;
                nextState                = REDIRECT;
            end
            MRET_STATUS: begin
                bus.csrReadCSR           = MSTATUS;
                bus.destinationCSR       = MSTATUS;
                bus.csrWriteData         = mretStatus(bus.csrReadData);
                bus.csrDestinationEnable = 1'b1;
                nextState                = REDIRECT;
            end
            REDIRECT: begin
                bus.redirectValid = 1'b1;
                if (isMret) begin
                    bus.csrReadCSR = MEPC;
                    bus.redirectPC = bus.csrReadData;
                end else begin
                    // Direct mode only: vectored interrupts are not supported.
                    bus.csrReadCSR = MTVEC;
                    bus.redirectPC = bus.csrReadData & ~32'd3;
                end
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase

        // Reset is asynchronous, so silence the CSR file and fetch the moment it rises.
        if (reset) begin
            nextState                = IDLE;
            takeException            = 1'b0;
            takeMret                 = 1'b0;
            takeInterrupt            = 1'b0;
            bus.busy                 = 1'b0;
            bus.destinationCSR       = MSTATUS;
            bus.csrWriteData         = '0;
            bus.csrDestinationEnable = 1'b0;
            bus.redirectValid        = 1'b0;
            bus.redirectPC           = '0;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Capture trap operands on the accepting IDLE cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            causeLatch <= '0;
            epcLatch   <= '0;
            tvalLatch  <= '0;
            isMret     <= 1'b0;
        end else if (takeException) begin
            causeLatch <= bus.exceptionCause;
            epcLatch   <= bus.exceptionPC;
            tvalLatch  <= bus.exceptionValue;
            isMret     <= 1'b0;
        end else if (takeMret) begin
            isMret <= 1'b1;
        end else if (takeInterrupt) begin
            causeLatch <= INT_CAUSE;
            epcLatch   <= bus.interruptPC;
            tvalLatch  <= '0;
            isMret     <= 1'b0;
        end
    end

    // Mirror of mstatus.MIE, following every MSTATUS write whoever issues it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mieShadow <= 1'b0;
        end else if (bus.csrDestinationEnable && (bus.destinationCSR == MSTATUS)) begin
            mieShadow <= bus.csrWriteData[MSTATUS_MIE];
        end
    end

endmodule
